// File: rtl/channel_word_aligner_if.sv
// Signal bundle between the deserializer side and channel_word_aligner.
// LOSS_CNT is present only when ALIGN_STATS_EN is defined.
interface channel_word_aligner_if #(
  parameter int N_CH  = 8,
  parameter int RATIO = 4
);
  localparam int SW = $clog2(RATIO);

  logic [N_CH*RATIO-1:0] DATA_IN;
  logic [N_CH-1:0]       DISABLE;
  logic                  TRAIN_EN;
  logic [N_CH*RATIO-1:0] DATA_OUT;
  logic [N_CH-1:0]       DATA_VALID;
  logic [N_CH-1:0]       LOCKED_CH;
  logic                  ALL_LOCKED;
  logic [N_CH*SW-1:0]    SLIP_POS;
`ifdef ALIGN_STATS_EN
  logic [N_CH*8-1:0]     LOSS_CNT;

  modport master (
    output DATA_IN, DISABLE, TRAIN_EN,
    input  DATA_OUT, DATA_VALID, LOCKED_CH, ALL_LOCKED, SLIP_POS, LOSS_CNT
  );
  modport slave (
    input  DATA_IN, DISABLE, TRAIN_EN,
    output DATA_OUT, DATA_VALID, LOCKED_CH, ALL_LOCKED, SLIP_POS, LOSS_CNT
  );
`else
  modport master (
    output DATA_IN, DISABLE, TRAIN_EN,
    input  DATA_OUT, DATA_VALID, LOCKED_CH, ALL_LOCKED, SLIP_POS
  );
  modport slave (
    input  DATA_IN, DISABLE, TRAIN_EN,
    output DATA_OUT, DATA_VALID, LOCKED_CH, ALL_LOCKED, SLIP_POS
  );
`endif
endinterface

// File: rtl/channel_word_aligner.sv
// Per-channel bit-slip search, lock tracking and word alignment after the 1:4 deserializers.
// Optional ALIGN_STATS_EN adds LOSS_CNT, a saturating per-channel count of lock losses.
//
// state  | meaning
// SEARCH | stepping the slip offset until the training word appears
// VERIFY | offset found, counting consecutive matches toward LOCK_CNT
// LOCKED | offset frozen, tolerating up to ERR_MAX-1 consecutive mismatches
module channel_word_aligner #(
  parameter int               N_CH     = 8,
  parameter int               RATIO    = 4,
  parameter logic [RATIO-1:0] PATTERN  = 4'b1100,
  parameter int               LOCK_CNT = 16,
  parameter int               ERR_MAX  = 4
) (
  input logic                   CLK_80,
  input logic                   RESET,
  channel_word_aligner_if.slave bus
);
  localparam int SW = $clog2(RATIO);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(ERR_MAX + 1);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  logic [RATIO-1:0]   prev_q  [N_CH];
  logic [2*RATIO-1:0] win     [N_CH];
  logic [RATIO-1:0]   aligned [N_CH];
  state_t             state_q [N_CH];
  state_t             state_d [N_CH];
  logic [SW-1:0]      k_q     [N_CH];
  logic [SW-1:0]      k_d     [N_CH];
  logic [CW-1:0]      cnt_q   [N_CH];
  logic [CW-1:0]      cnt_d   [N_CH];
  logic [EW-1:0]      err_q   [N_CH];
  logic [EW-1:0]      err_d   [N_CH];
  logic [N_CH-1:0]    match;
  logic [N_CH-1:0]    locked_d;

  logic [N_CH*RATIO-1:0] data_out_q;
  logic [N_CH-1:0]       data_valid_q;
  logic                  all_locked_q;
  logic [N_CH-1:0]       locked_ch;
  logic [N_CH*SW-1:0]    slip_pos;

  function automatic logic [SW-1:0] next_k(input logic [SW-1:0] k);
    return (k == SW'(RATIO - 1)) ? '0 : k + SW'(1);
  endfunction

  // The previous word occupies the low half of the window.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      win[c]     = {bus.DATA_IN[c*RATIO +: RATIO], prev_q[c]};
      aligned[c] = win[c][k_q[c] +: RATIO];
      match[c]   = (aligned[c] == PATTERN);
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      state_d[c] = state_q[c];
      k_d[c]     = k_q[c];
      cnt_d[c]   = cnt_q[c];
      err_d[c]   = err_q[c];
      if (bus.DISABLE[c]) begin
        state_d[c] = SEARCH;
        k_d[c]     = '0;
        cnt_d[c]   = '0;
        err_d[c]   = '0;
      end else if (bus.TRAIN_EN) begin
        case (state_q[c])
          SEARCH: begin
            if (match[c]) begin
              state_d[c] = VERIFY;
              cnt_d[c]   = CW'(1);
            end else begin
              k_d[c] = next_k(k_q[c]);
            end
          end
          VERIFY: begin
            if (!match[c]) begin
              state_d[c] = SEARCH;
              k_d[c]     = next_k(k_q[c]);
              cnt_d[c]   = '0;
            end else if (cnt_q[c] == CW'(LOCK_CNT - 1)) begin
              state_d[c] = LOCKED;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_q[c] + CW'(1);
            end
          end
          LOCKED: begin
            if (match[c]) begin
              err_d[c] = '0;
            end else if (err_q[c] == EW'(ERR_MAX - 1)) begin
              state_d[c] = SEARCH;
              err_d[c]   = '0;
              cnt_d[c]   = '0;
            end else begin
              err_d[c] = err_q[c] + EW'(1);
            end
          end
          default: begin
            state_d[c] = SEARCH;
            k_d[c]     = '0;
            cnt_d[c]   = '0;
            err_d[c]   = '0;
          end
        endcase
      end
      locked_d[c] = (state_d[c] == LOCKED);
    end
  end

  // DATA_VALID and ALL_LOCKED are built from the next lock state so they
  // line up with LOCKED_CH at the same edge.
  always_ff @(posedge CLK_80) begin
    if (RESET) begin
      for (int c = 0; c < N_CH; c++) begin
        prev_q[c]  <= '0;
        state_q[c] <= SEARCH;
        k_q[c]     <= '0;
        cnt_q[c]   <= '0;
        err_q[c]   <= '0;
      end
      data_out_q   <= '0;
      data_valid_q <= '0;
      all_locked_q <= 1'b0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        prev_q[c]  <= bus.DATA_IN[c*RATIO +: RATIO];
        state_q[c] <= state_d[c];
        k_q[c]     <= k_d[c];
        cnt_q[c]   <= cnt_d[c];
        err_q[c]   <= err_d[c];
        data_out_q[c*RATIO +: RATIO] <= bus.DISABLE[c] ? '0 : aligned[c];
      end
      data_valid_q <= locked_d & ~bus.DISABLE;
      all_locked_q <= (&(locked_d | bus.DISABLE)) & ~(&bus.DISABLE);
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      locked_ch[c]            = (state_q[c] == LOCKED);
      slip_pos[c*SW +: SW]    = k_q[c];
    end
  end

  assign bus.DATA_OUT   = data_out_q;
  assign bus.DATA_VALID = data_valid_q;
  assign bus.LOCKED_CH  = locked_ch;
  assign bus.ALL_LOCKED = all_locked_q;
  assign bus.SLIP_POS   = slip_pos;

`ifdef ALIGN_STATS_EN
  logic [7:0]        loss_q [N_CH];
  logic [N_CH*8-1:0] loss_cnt;

  // Any exit from LOCKED counts, including one forced by DISABLE.
  always_ff @(posedge CLK_80) begin
    if (RESET) begin
      for (int c = 0; c < N_CH; c++) loss_q[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (state_q[c] == LOCKED && state_d[c] == SEARCH && loss_q[c] != 8'hFF)
          loss_q[c] <= loss_q[c] + 8'd1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) loss_cnt[c*8 +: 8] = loss_q[c];
  end

  assign bus.LOSS_CNT = loss_cnt;
`endif
endmodule

// File: tb/tb_channel_word_aligner.sv
// Scoreboard bench for channel_word_aligner: directed plan steps plus a random soak,
// checked against a lock-run/miss-run reference model.
module tb_channel_word_aligner;
  localparam int N_CH     = 8;
  localparam int R        = 4;
  localparam int SW       = 2;
  localparam int LOCK_CNT = 16;
  localparam int ERR_MAX  = 4;
  localparam logic [R-1:0] PATTERN = 4'b1100;
  localparam int MASK = (1 << R) - 1;

  typedef struct {
    logic [N_CH*R-1:0]  dout;
    logic [N_CH-1:0]    valid;
    logic [N_CH-1:0]    locked;
    logic               all_lk;
    logic [N_CH*SW-1:0] slip;
    logic [N_CH*8-1:0]  loss;
  } exp_t;

  logic clk_80 = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_fail = 0;
  exp_t sb[$];

  int  m_prev[N_CH];
  int  m_k[N_CH];
  int  m_run[N_CH];
  int  m_miss[N_CH];
  int  m_loss[N_CH];
  bit  m_lock[N_CH];
  int  rot[N_CH];

  initial forever #5 clk_80 = ~clk_80;

  channel_word_aligner_if #(.N_CH(N_CH), .RATIO(R)) bus ();

  channel_word_aligner #(
    .N_CH(N_CH), .RATIO(R), .PATTERN(PATTERN), .LOCK_CNT(LOCK_CNT), .ERR_MAX(ERR_MAX)
  ) dut (
    .CLK_80(clk_80),
    .RESET (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a channel is locked after LOCK_CNT consecutive hits at a fixed
  // offset; any miss while unlocked restarts the run at the next offset.
  task automatic model_step(input logic [N_CH*R-1:0] din, input logic [N_CH-1:0] dis,
                            input logic train, input logic rst, output exp_t e);
    bit every;
    e.dout = '0; e.valid = '0; e.locked = '0; e.all_lk = 1'b0; e.slip = '0; e.loss = '0;
    every = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      int w, word;
      bit hit, was;
      w    = int'(din[c*R +: R]);
      word = (((w << R) | m_prev[c]) >> m_k[c]) & MASK;
      if (rst) begin
        m_prev[c] = 0; m_k[c] = 0; m_run[c] = 0; m_miss[c] = 0; m_lock[c] = 0; m_loss[c] = 0;
      end else begin
        hit = (word == int'(PATTERN));
        was = m_lock[c];
        if (dis[c]) begin
          m_lock[c] = 0; m_run[c] = 0; m_miss[c] = 0; m_k[c] = 0;
        end else if (train) begin
          if (m_lock[c]) begin
            m_miss[c] = hit ? 0 : m_miss[c] + 1;
            if (m_miss[c] == ERR_MAX) begin
              m_lock[c] = 0; m_miss[c] = 0; m_run[c] = 0;
            end
          end else if (hit) begin
            m_run[c]++;
            if (m_run[c] == LOCK_CNT) begin
              m_lock[c] = 1; m_run[c] = 0;
            end
          end else begin
            m_run[c] = 0;
            m_k[c]   = (m_k[c] + 1) % R;
          end
        end
        if (was && !m_lock[c] && m_loss[c] < 255) m_loss[c]++;
        m_prev[c] = w;
        e.dout[c*R +: R]    = dis[c] ? '0 : R'(word);
        e.valid[c]          = m_lock[c] & ~dis[c];
        e.locked[c]         = m_lock[c];
        e.slip[c*SW +: SW]  = SW'(m_k[c]);
        e.loss[c*8 +: 8]    = 8'(m_loss[c]);
        if (!(m_lock[c] || dis[c])) every = 1'b0;
      end
    end
    e.all_lk = !rst && every && (dis != '1);
  endtask

  task automatic cycle(input logic [N_CH*R-1:0] din, input logic [N_CH-1:0] dis,
                       input logic train, input logic rst);
    exp_t e;
    bus.DATA_IN  = din;
    bus.DISABLE  = dis;
    bus.TRAIN_EN = train;
    reset        = rst;
    model_step(din, dis, train, rst, e);
    sb.push_back(e);
    @(posedge clk_80);
    #1;
  endtask

  function automatic logic [R-1:0] rotp(input int r);
    logic [2*R-1:0] d;
    d = {PATTERN, PATTERN};
    return d[r +: R];
  endfunction

  function automatic logic [N_CH*R-1:0] trained();
    logic [N_CH*R-1:0] v;
    for (int c = 0; c < N_CH; c++) v[c*R +: R] = rotp(rot[c]);
    return v;
  endfunction

  function automatic logic [N_CH*R-1:0] with_ch0(input logic [R-1:0] w);
    logic [N_CH*R-1:0] v;
    v = trained();
    v[R-1:0] = w;
    return v;
  endfunction

  // Monitor: outputs are registered every cycle, so one expectation per edge.
  initial begin
    forever begin
      @(negedge clk_80);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("data_out",   64'(bus.DATA_OUT),   64'(e.dout));
        check("data_valid", 64'(bus.DATA_VALID), 64'(e.valid));
        check("locked_ch",  64'(bus.LOCKED_CH),  64'(e.locked));
        check("all_locked", 64'(bus.ALL_LOCKED), 64'(e.all_lk));
        check("slip_pos",   64'(bus.SLIP_POS),   64'(e.slip));
`ifdef ALIGN_STATS_EN
        check("loss_cnt",   64'(bus.LOSS_CNT),   64'(e.loss));
`endif
      end
    end
  end

  initial begin
    logic [N_CH*R-1:0] d;
    logic [N_CH-1:0]   dis;
    for (int c = 0; c < N_CH; c++) rot[c] = (c + 2) % R;

    // Reset with random data
    for (int i = 0; i < 3; i++) cycle({$urandom, $urandom} , '0, 1'b1, 1'b1);
    check("reset_locked", 64'(bus.LOCKED_CH), 64'd0);
    check("reset_slip",   64'(bus.SLIP_POS),  64'd0);

    // Lock from reset: ch0 sees 0011 and locks at k=2 on edge 18
    for (int i = 0; i < 24; i++) begin
      cycle(with_ch0(4'b0011), '0, 1'b1, 1'b0);
      if (i == 16) check("ch0_not_yet_locked", 64'(bus.LOCKED_CH[0]), 64'd0);
      if (i == 17) begin
        check("ch0_locked_edge18", 64'(bus.LOCKED_CH[0]), 64'd1);
        check("ch0_slip",          64'(bus.SLIP_POS[1:0]), 64'd2);
        check("ch0_word",          64'(bus.DATA_OUT[3:0]), 64'(4'b1100));
        check("ch0_valid",         64'(bus.DATA_VALID[0]), 64'd1);
      end
    end
    check("all_locked_trained", 64'(bus.ALL_LOCKED), 64'd1);

    // Error tolerance: 3 bad words recover, 4 bad words drop lock
    for (int j = 0; j < 12; j++) begin
      d = with_ch0((j < 3 || (j >= 5 && j < 9)) ? 4'b0000 : 4'b0011);
      cycle(d, '0, 1'b1, 1'b0);
      if (j == 4 || j == 7) check("ch0_still_locked", 64'(bus.LOCKED_CH[0]), 64'd1);
      if (j == 8) begin
        check("ch0_lock_lost", 64'(bus.LOCKED_CH[0]), 64'd0);
`ifdef ALIGN_STATS_EN
        check("ch0_loss_cnt", 64'(bus.LOSS_CNT[7:0]), 64'd1);
`endif
      end
    end

    // Disable ch3 with random data on it
    cycle(trained(), 8'h08, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) begin
      d = trained();
      d[3*R +: R] = R'($urandom);
      cycle(d, 8'h08, 1'b1, 1'b0);
    end
    check("all_locked_ch3_off", 64'(bus.ALL_LOCKED),     64'd1);
    check("ch3_dout_zero",      64'(bus.DATA_OUT[15:12]), 64'd0);
    check("ch3_valid_zero",     64'(bus.DATA_VALID[3]),  64'd0);
    cycle(trained(), 8'hFF, 1'b1, 1'b0);
    check("all_locked_all_off", 64'(bus.ALL_LOCKED), 64'd0);

    // Reset pulse while ch0 is in VERIFY with count 7
    cycle(trained(), '0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(with_ch0(4'b0011), '0, 1'b1, (i == 9));
      if (i == 8) check("ch0_verify_slip", 64'(bus.SLIP_POS[1:0]), 64'd2);
    end
    check("mid_reset_slip",   64'(bus.SLIP_POS),  64'd0);
    check("mid_reset_locked", 64'(bus.LOCKED_CH), 64'd0);
    for (int i = 0; i < 18; i++) begin
      cycle(with_ch0(4'b0011), '0, 1'b1, 1'b0);
      if (i == 16) check("relock_not_yet", 64'(bus.LOCKED_CH[0]), 64'd0);
      if (i == 17) check("relock_edge18",  64'(bus.LOCKED_CH[0]), 64'd1);
    end

    // Training off: lock and offset hold regardless of data
    for (int i = 0; i < 10; i++) begin
      cycle({$urandom, $urandom}, '0, 1'b0, 1'b0);
      check("hold_locked", 64'(bus.LOCKED_CH[0]),  64'd1);
      check("hold_slip",   64'(bus.SLIP_POS[1:0]), 64'd2);
    end

    // Random soak
    dis = '0;
    for (int i = 0; i < 800; i++) begin
      if (i % 150 == 0)
        for (int c = 0; c < N_CH; c++) rot[c] = int'($urandom_range(0, R - 1));
      if (i % 60 == 0) dis = N_CH'($urandom & $urandom & $urandom);
      d = trained();
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 15) == 0) d[c*R +: R] = R'($urandom);
      cycle(d, dis, ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0));
    end

    @(negedge clk_80);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
